// File: rtl/btn_pkg.sv
// Shared constants for the button input peripheral: register word indices
// and the MMIO base the top-level decoder places this block at.
package btn_pkg;

  localparam logic [1:0] BTN_REG_STATE   = 2'd0;
  localparam logic [1:0] BTN_REG_PRESS   = 2'd1;
  localparam logic [1:0] BTN_REG_RELEASE = 2'd2;
  localparam logic [1:0] BTN_REG_IRQ_EN  = 2'd3;

  localparam logic [31:0] BTN_MMIO_BASE = 32'h4000_2000;

endpackage

// File: rtl/btn_input_if.sv
// Single-cycle request register bus between the CPU MMIO decode and the
// button peripheral; the ack and read data return one cycle after the request.
interface btn_input_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ack);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output rdata, output ack);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a stable-level debouncer that
// flips only after a mismatch persists for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 800000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // The edge that accepts the new level is the DEBOUNCE_CYCLES-th mismatched cycle.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = stable;
  assign rise = accept & sync2;
  assign fall = accept & ~sync2;

endmodule

// File: rtl/btn_input.sv
// Button input peripheral: debounced levels, sticky press/release flags with
// write-1-to-clear, interrupt enable mask and a registered level interrupt.
module btn_input
  import btn_pkg::*;
#(
  parameter int NBTN            = 4,
  parameter int DEBOUNCE_CYCLES = 800000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NBTN-1:0] btn_raw,
  btn_input_if.slave      bus,
  output logic [NBTN-1:0] btn_db,
  output logic            irq
);

  logic [NBTN-1:0] db_lvl;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] fall;
  logic [NBTN-1:0] press_q;
  logic [NBTN-1:0] rel_q;
  logic [NBTN-1:0] irq_en_q;
  logic [NBTN-1:0] press_clr;
  logic [NBTN-1:0] rel_clr;
  logic            wr;
  logic [31:0]     rd_word;
  logic [31:0]     rdata_q;
  logic            ack_q;
  logic            irq_q;
  logic            unused_wdata;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (btn_raw[i]),
      .dout    (db_lvl[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign wr        = bus.req & bus.we;
  assign press_clr = (wr && bus.addr == BTN_REG_PRESS)   ? bus.wdata[NBTN-1:0] : '0;
  assign rel_clr   = (wr && bus.addr == BTN_REG_RELEASE) ? bus.wdata[NBTN-1:0] : '0;
  assign unused_wdata = ^bus.wdata;

  // Read mux samples pre-edge values, so a read returns flags before any clear.
  always_comb begin
    rd_word = '0;
    case (bus.addr)
      BTN_REG_STATE:   rd_word[NBTN-1:0] = db_lvl;
      BTN_REG_PRESS:   rd_word[NBTN-1:0] = press_q;
      BTN_REG_RELEASE: rd_word[NBTN-1:0] = rel_q;
      BTN_REG_IRQ_EN:  rd_word[NBTN-1:0] = irq_en_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q  <= '0;
      rel_q    <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // A new event outranks a clear landing on the same edge.
      press_q <= (press_q & ~press_clr) | rise;
      rel_q   <= (rel_q & ~rel_clr) | fall;
      if (wr && bus.addr == BTN_REG_IRQ_EN) begin
        irq_en_q <= bus.wdata[NBTN-1:0];
      end
      irq_q   <= |(press_q & irq_en_q);
      ack_q   <= bus.req;
      rdata_q <= bus.req ? rd_word : '0;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign btn_db    = db_lvl;
  assign irq       = irq_q;

endmodule

// File: tb/tb_btn_input.sv
// Directed bench for btn_input with DEBOUNCE_CYCLES=4, NBTN=4; expected values
// are hand-derived from the debounce latency (edge k+1+4) and register rules.
module tb_btn_input;
  import btn_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  logic       irq;
  int         vectors;
  int         miscompares;

  btn_input_if bus();

  btn_input #(.NBTN(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_raw),
    .bus     (bus.slave),
    .btn_db  (btn_db),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = addr;
    bus.wdata = data;
    tick(1);
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = addr;
    tick(1);
    bus.req  = 1'b0;
    check({tag, "_ack"}, {31'd0, bus.ack}, 32'd1);
    check(tag, bus.rdata, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    btn_raw     = 4'b1111;
    bus.req     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 2'd0;
    bus.wdata   = '0;

    // Reset with all buttons held
    tick(2);
    check("rst_btn_db", {28'd0, btn_db}, 32'h0);
    check("rst_irq",    {31'd0, irq}, 32'h0);
    check("rst_ack",    {31'd0, bus.ack}, 32'h0);
    check("rst_rdata",  bus.rdata, 32'h0);
    reset_n = 1'b1;
    tick(5);
    check("held_edge5_db", {28'd0, btn_db}, 32'h0);
    tick(1);
    check("held_edge6_db", {28'd0, btn_db}, 32'hF);
    bus_read(BTN_REG_PRESS, 32'h0000000F, "held_press");
    tick(1);
    check("idle_ack",   {31'd0, bus.ack}, 32'h0);
    check("idle_rdata", bus.rdata, 32'h0);

    // Release all, clear flags
    btn_raw = 4'b0000;
    tick(8);
    check("all_rel_db", {28'd0, btn_db}, 32'h0);
    bus_read(BTN_REG_RELEASE, 32'hF, "all_rel_flags");
    bus_write(BTN_REG_PRESS, 32'hF);
    bus_write(BTN_REG_RELEASE, 32'hF);
    bus_read(BTN_REG_PRESS, 32'h0, "press_cleared");

    // Glitch of 3 cycles is rejected
    btn_raw[1] = 1'b1;
    tick(3);
    btn_raw[1] = 1'b0;
    tick(8);
    check("glitch_db", {28'd0, btn_db}, 32'h0);
    bus_read(BTN_REG_PRESS, 32'h0, "glitch_press");

    // 4-cycle hold is accepted at edge j+6
    btn_raw[1] = 1'b1;
    tick(5);
    check("hold4_edge5_db", {28'd0, btn_db}, 32'h0);
    tick(1);
    check("hold4_edge6_db", {28'd0, btn_db}, 32'h2);
    bus_read(BTN_REG_PRESS, 32'h2, "hold4_press");
    btn_raw[1] = 1'b0;
    tick(8);
    bus_read(BTN_REG_RELEASE, 32'h2, "b1_release");
    bus_write(BTN_REG_PRESS, 32'h2);
    bus_write(BTN_REG_RELEASE, 32'h2);

    // Button 2 press/release and W1C
    btn_raw[2] = 1'b1;
    tick(8);
    btn_raw[2] = 1'b0;
    tick(8);
    bus_read(BTN_REG_RELEASE, 32'h4, "b2_release");
    bus_write(BTN_REG_RELEASE, 32'h0);
    bus_read(BTN_REG_RELEASE, 32'h4, "w0_no_effect");
    bus_write(BTN_REG_RELEASE, 32'h4);
    bus_read(BTN_REG_RELEASE, 32'h0, "w1c_release");
    bus_read(BTN_REG_PRESS, 32'h4, "b2_press");
    bus_write(BTN_REG_PRESS, 32'h4);

    // W1C of PRESS[0] on the very edge the rise is accepted: set wins
    btn_raw[0] = 1'b1;
    tick(5);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = BTN_REG_PRESS;
    bus.wdata = 32'h1;
    tick(1);
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    check("collide_db", {28'd0, btn_db}, 32'h1);
    bus_read(BTN_REG_PRESS, 32'h1, "collide_press");
    bus_write(BTN_REG_PRESS, 32'h1);
    bus_read(BTN_REG_PRESS, 32'h0, "collide_cleared");

    // Interrupt on button 3 only
    bus_write(BTN_REG_IRQ_EN, 32'h8);
    check("irq_en_idle", {31'd0, irq}, 32'h0);
    btn_raw[3] = 1'b1;
    tick(6);
    check("irq_flag_edge", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_asserted", {31'd0, irq}, 32'h1);
    bus_write(BTN_REG_PRESS, 32'h8);
    check("irq_clear_edge", {31'd0, irq}, 32'h1);
    tick(1);
    check("irq_deasserted", {31'd0, irq}, 32'h0);

    // Masked button 0 press leaves irq low
    btn_raw[0] = 1'b0;
    tick(8);
    btn_raw[0] = 1'b1;
    tick(8);
    check("irq_masked", {31'd0, irq}, 32'h0);
    bus_read(BTN_REG_PRESS, 32'h1, "masked_press");
    bus_write(BTN_REG_RELEASE, 32'hF);

    // Back-to-back reads: STATE=9 PRESS=1 RELEASE=0 IRQ_EN=8
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = BTN_REG_STATE;
    tick(1);
    check("b2b0_ack", {31'd0, bus.ack}, 32'h1);
    check("b2b0_data", bus.rdata, 32'h9);
    bus.addr = BTN_REG_PRESS;
    tick(1);
    check("b2b1_ack", {31'd0, bus.ack}, 32'h1);
    check("b2b1_data", bus.rdata, 32'h1);
    bus.addr = BTN_REG_RELEASE;
    tick(1);
    check("b2b2_ack", {31'd0, bus.ack}, 32'h1);
    check("b2b2_data", bus.rdata, 32'h0);
    bus.addr = BTN_REG_IRQ_EN;
    tick(1);
    check("b2b3_ack", {31'd0, bus.ack}, 32'h1);
    check("b2b3_data", bus.rdata, 32'h8);
    bus.req = 1'b0;
    tick(1);
    check("b2b_end_ack", {31'd0, bus.ack}, 32'h0);
    check("b2b_end_rdata", bus.rdata, 32'h0);

    // Upper bits ignored, STATE read-only
    bus_write(BTN_REG_IRQ_EN, 32'hFFFFFFFF);
    bus_read(BTN_REG_IRQ_EN, 32'h0000000F, "irq_en_upper");
    check("irq_all_en", {31'd0, irq}, 32'h1);
    bus_write(BTN_REG_STATE, 32'h0);
    bus_read(BTN_REG_STATE, 32'h9, "state_ro");

    // Reset mid-access discards everything, held buttons re-debounce
    bus.req  = 1'b1;
    bus.addr = BTN_REG_PRESS;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_irq", {31'd0, irq}, 32'h0);
    tick(1);
    bus.req = 1'b0;
    check("midrst_ack", {31'd0, bus.ack}, 32'h0);
    check("midrst_db", {28'd0, btn_db}, 32'h0);
    reset_n = 1'b1;
    tick(5);
    check("rerst_edge5_db", {28'd0, btn_db}, 32'h0);
    tick(1);
    check("rerst_edge6_db", {28'd0, btn_db}, 32'h9);
    bus_read(BTN_REG_PRESS, 32'h9, "rerst_press");
    bus_read(BTN_REG_IRQ_EN, 32'h0, "rerst_irq_en");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
